// File: rtl/vc_bus_pkg.sv
// Shared types and constants for the vc CPU byte-serial bus target.
// Pin indices refer to the CPU's uio_out / uio_in pin numbering.
package vc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2
  } rd_phase_t;

  localparam int PIN_LATCH_HI = 3;
  localparam int PIN_LATCH_LO = 2;
  localparam int PIN_WRITE    = 1;
  localparam int PIN_IND      = 0;
  localparam int IRQ_BIT      = 7;

endpackage

// File: rtl/vc_bus_if.sv
// Pin-level vc CPU bus as seen between the CPU tile and the memory-side target.
// Handshake: no valid/ready; each strobe is sampled on every rising clk edge and acts
// in that cycle only, with bus_data qualified by whichever strobe is high.
interface vc_bus_if;
  logic [7:0] bus_data;
  logic       latch_hi;
  logic       latch_lo;
  logic       write;
  logic       ind;
  logic [7:0] rd_data;
  logic       irq;

  modport master (
    output bus_data, latch_hi, latch_lo, write, ind,
    input  rd_data, irq
  );

  modport slave (
    input  bus_data, latch_hi, latch_lo, write, ind,
    output rd_data, irq
  );
endinterface

// File: rtl/vc_bus_ram.sv
// Byte RAM for the bus target: two async read ports, a bus write port and a backdoor
// write port; the bus write takes the byte when both ports hit the same address.
module vc_bus_ram #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] ra_addr,
  output logic [7:0]    ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [7:0]    rb_data,
  input  logic          bus_we,
  input  logic [AW-1:0] bus_addr,
  input  logic [7:0]    bus_wdata,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_wdata
);
  logic [7:0] mem [0:(1<<AW)-1];

  logic ld_blocked;
  assign ld_blocked = bus_we && (bus_addr == ld_addr);

  always_ff @(posedge clk) begin
    if (ld_we && !ld_blocked) mem[ld_addr] <= ld_wdata;
    if (bus_we)               mem[bus_addr] <= bus_wdata;
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];
endmodule

// File: rtl/vc_bus_target.sv
// Memory-side responder for the vc CPU byte-serial bus: address capture, byte writes,
// two-slot read return. Define VC_TARGET_IRQ_EN to map a doorbell/irq byte at IRQ_ADDR.
module vc_bus_target
  import vc_bus_pkg::*;
#(
  parameter int          MEM_AW   = 9,
  parameter logic [15:0] IRQ_ADDR = 16'hFFFE
) (
  input  logic              clk,
  input  logic              rst_n,
  vc_bus_if.slave           bus,
  input  logic              ld_we,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output rd_phase_t         dbg_rd_phase
);
`ifdef VC_TARGET_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic [7:0] addr_hi, addr_lo;
  logic       lo_arm;
  rd_phase_t  rd_phase, rd_phase_nxt;
  logic [7:0] rd_data_q, rd_data_nxt;
  logic       irq_q, irq_nxt;

  logic        capture;
  logic [15:0] wr_addr16, rd0_addr16, rd1_addr16;
  logic        wr_irq, rd0_irq, rd1_irq;
  logic [7:0]  rd0_byte, rd1_byte;

  // latch_hi in the same cycle as latch_lo wins; the low byte is taken later.
  assign capture    = bus.latch_lo && lo_arm && !bus.latch_hi;
  assign wr_addr16  = {addr_hi, addr_lo[7:1], addr_lo[0] | bus.ind};
  // First read slot indexes with the pin byte so data is ready on the capture edge.
  assign rd0_addr16 = {addr_hi, bus.bus_data[7:1], 1'b0};
  assign rd1_addr16 = {addr_hi, addr_lo[7:1], 1'b1};

  assign wr_irq  = IRQ_EN && bus.write && (wr_addr16 == IRQ_ADDR);
  assign rd0_irq = IRQ_EN && (rd0_addr16 == IRQ_ADDR);
  assign rd1_irq = IRQ_EN && (rd1_addr16 == IRQ_ADDR);

  vc_bus_ram #(.AW(MEM_AW)) u_ram (
    .clk       (clk),
    .ra_addr   (rd0_addr16[MEM_AW-1:0]),
    .ra_data   (rd0_byte),
    .rb_addr   (rd1_addr16[MEM_AW-1:0]),
    .rb_data   (rd1_byte),
    .bus_we    (bus.write && !wr_irq && rst_n),
    .bus_addr  (wr_addr16[MEM_AW-1:0]),
    .bus_wdata (bus.bus_data),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hi <= 8'h00;
      addr_lo <= 8'h00;
      lo_arm  <= 1'b0;
    end else if (bus.latch_hi) begin
      addr_hi <= bus.bus_data;
      lo_arm  <= 1'b1;
    end else if (capture) begin
      addr_lo <= bus.bus_data;
      lo_arm  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_phase  <= IDLE;
      rd_data_q <= 8'h00;
      irq_q     <= 1'b0;
    end else begin
      rd_phase  <= rd_phase_nxt;
      rd_data_q <= rd_data_nxt;
      irq_q     <= irq_nxt;
    end
  end

  always_comb begin
    rd_phase_nxt = rd_phase;
    rd_data_nxt  = rd_data_q;
    irq_nxt      = wr_irq ? (|bus.bus_data) : irq_q;
    if (capture) begin
      rd_phase_nxt = RD0;
      rd_data_nxt  = rd0_irq ? {7'b0, irq_q} : rd0_byte;
    end else begin
      case (rd_phase)
        RD0: begin
          rd_phase_nxt = RD1;
          rd_data_nxt  = rd1_irq ? {7'b0, irq_q} : rd1_byte;
        end
        RD1:     rd_phase_nxt = IDLE;
        default: rd_phase_nxt = IDLE;
      endcase
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.irq       = irq_q;
  assign dbg_rd_phase  = rd_phase;
endmodule
